lsu_mem_initiator: RTL and testbench
====================================

Name: lsu_mem_initiator

Overview:
- MEM-stage requester that drives the byte-addressed data-memory port (addr / penable / pwrite / pwdata / funct code / prdata).
- Accepts one load/store at a time from the pipeline over a valid/ready handshake and performs legality, range and alignment checks.
- Issues the memory access and returns a single-cycle response with load data or an error flag.

Parameters:
- DMEM_ADDR, 13, byte-address width of the memory port.
- DMEM_DEPTH, 8192, number of valid bytes; the highest legal byte address is DMEM_DEPTH-1.

Ports:
- i_clk  in  1  clock; everything is on the rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request can be accepted (high only in IDLE).
- i_req_we  in  1  1 = store, 0 = load.
- i_req_addr  in  32  byte address.
- i_req_wdata  in  32  store data, right-aligned.
- i_req_funct  in  3  funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- o_rsp_valid  out  1  one-cycle response pulse.
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors.
- o_rsp_err  out  1  illegal funct, out-of-range address, or misaligned access.
- po_lsu_addr  out  DMEM_ADDR  memory byte address.
- penable_o  out  1  memory select.
- pwrite_o  out  1  memory write enable.
- pwdata_o  out  32  memory write data.
- pfunct_code_o  out  3  memory access kind.
- prdata_i  in  32  memory read data, combinational from the port.

Behaviour:
- Reset (sync, i_rst=1 at an edge):
  - State goes to IDLE; request registers clear.
  - o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0.
  - All p* outputs are 0 from the next cycle.
  - A store already driven on that same edge still commits, because memory has no reset.
  - A mid-operation reset drops the transaction; no response is produced.
- Bus outputs are decoded from registered state only, with no input-to-output combinational path.
- Outside access states, every p* output is 0.
- FSM states: IDLE, ACCESS, SPLIT (macro only), RESP.
- IDLE:
  - o_req_ready=1.
  - On i_req_valid, capture we/addr/wdata/funct in cycle T.
  - size = 1/2/4 bytes for funct[1:0] = 00/01/10.
- Error checks, evaluated in IDLE at capture:
  - illegal funct: loads not in {000,001,010,100,101}; stores not in {000,001,010}.
  - out of range: addr + size - 1 > DMEM_DEPTH-1, computed in 33 bits with no wrap.
  - misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- Error path: IDLE -> RESP. Response at T+1 with err=1, rdata=0. No bus activity.
- Aligned legal path: IDLE -> ACCESS (cycle T+1) -> RESP (cycle T+2) -> IDLE.
  - In ACCESS: penable_o=1, pwrite_o=we, po_lsu_addr=addr[DMEM_ADDR-1:0], pwdata_o=wdata, pfunct_code_o=funct, all for exactly one cycle.
  - Loads: prdata_i is registered at the end of ACCESS.
  - RESP: o_rsp_valid=1 for one cycle, rdata = registered value (memory already extends it), err=0.
- Response has no backpressure; the consumer must take it.
- Back-to-back: the next request is accepted in the cycle after RESP. Minimum throughput is one access per 3 cycles.
- i_req_valid seen outside IDLE is ignored, since ready=0.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Without the macro: misaligned access is an error, as above.
- With the macro: misaligned but in-range access goes IDLE -> SPLIT.
  - A 2-bit byte counter k = 0..size-1 issues one byte access per cycle.
  - Each access: addr+k; funct 100 (LBU) for loads or 000 (SB) for stores; pwdata_o[7:0] = wdata byte k, upper bits 0.
  - Load bytes are assembled little-endian into byte k of a holding register.
  - After the last byte, go to RESP. The result is sign-extended for LB/LH, zero-extended for LHU.
  - Response arrives at T+1+size.
  - Range and funct errors still take precedence; no bytes are issued for them.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (LB..LHU, SB..SW);
  - typedef enum lsu_state_e {IDLE, ACCESS, SPLIT, RESP};
  - function funct_size(funct) returning bytes;
  - function load_extend(funct, raw32).
- One natural sub-module, lsu_req_check: a combinational legality/range/alignment checker outputting err and size.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF -> penable_o=pwrite_o=1 only in cycle T+1 with pfunct_code_o=010; rsp_valid at T+2, err=0, rdata=0. Then LW 0x10 -> rdata 0xDEADBEEF at T+2.
- Memory bytes 0x10..0x13 = EF BE AD DE:
  - LB 0x10 -> 0xFFFFFFEF;
  - LBU 0x10 -> 0x000000EF;
  - LH 0x12 -> 0xFFFFDEAD;
  - LHU 0x12 -> 0x0000DEAD.
- Misaligned LW 0x11:
  - without macro -> err=1 at T+1, no penable pulse;
  - with macro -> 4 byte reads at 0x11..0x14, rdata 0x??DEADBE per memory, response at T+5.
- Range: LW 0x00001FFC -> ok; LH 0x00002000 -> err=1; SB 0xFFFFFFFF -> err=1, no bus activity.
- Illegal funct: load 011 or store 100 -> err=1 at T+1.
- Reset asserted while in ACCESS of a store -> that edge's write commits, no rsp_valid; ready=1 the cycle after reset is released.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state type and size/extension helpers for the
// MEM-stage load/store initiator.
package lsu_pkg;

    localparam logic [2:0] F_LB  = 3'b000;
    localparam logic [2:0] F_LH  = 3'b001;
    localparam logic [2:0] F_LW  = 3'b010;
    localparam logic [2:0] F_LBU = 3'b100;
    localparam logic [2:0] F_LHU = 3'b101;
    localparam logic [2:0] F_SB  = 3'b000;
    localparam logic [2:0] F_SH  = 3'b001;
    localparam logic [2:0] F_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        SPLIT  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

    function automatic logic [2:0] funct_size(input logic [2:0] funct);
        case (funct[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] funct, input logic [31:0] raw);
        case (funct)
            F_LB:    return {{24{raw[7]}}, raw[7:0]};
            F_LH:    return {{16{raw[15]}}, raw[15:0]};
            F_LBU:   return {24'd0, raw[7:0]};
            F_LHU:   return {16'd0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_req_check.sv
// Combinational request legality / range / alignment checker.
// LSU_MISALIGN_SPLIT_EN turns legal misaligned accesses into byte splits.
module lsu_req_check
    import lsu_pkg::*;
#(
    parameter int DMEM_DEPTH = 8192
) (
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_funct,
    output logic        o_err,
    output logic        o_split,
    output logic [2:0]  o_size
);

    logic        illegal;
    logic        out_of_range;
    logic        misaligned;
    logic [32:0] last_byte;

    always_comb begin
        o_size = funct_size(i_funct);
        if (i_we) begin
            illegal = !(i_funct == F_SB || i_funct == F_SH || i_funct == F_SW);
        end else begin
            illegal = !(i_funct == F_LB || i_funct == F_LH || i_funct == F_LW ||
                        i_funct == F_LBU || i_funct == F_LHU);
        end
        // 33-bit sum so an access near 0xFFFFFFFF cannot wrap back into range
        last_byte    = {1'b0, i_addr} + {30'd0, o_size} - 33'd1;
        out_of_range = last_byte > 33'(DMEM_DEPTH - 1);
        misaligned   = (o_size == 3'd2 && i_addr[0]) ||
                       (o_size == 3'd4 && i_addr[1:0] != 2'b00);
`ifdef LSU_MISALIGN_SPLIT_EN
        o_err   = illegal || out_of_range;
        o_split = misaligned && !o_err;
`else
        o_err   = illegal || out_of_range || misaligned;
        o_split = 1'b0;
`endif
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// MEM-stage initiator: one load/store at a time, checked, issued on the
// data-memory port, answered with a single-cycle response. Optional byte
// splitting of misaligned accesses under LSU_MISALIGN_SPLIT_EN.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int DMEM_ADDR  = 13,
    parameter int DMEM_DEPTH = 8192
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_we,
    input  logic [31:0]          i_req_addr,
    input  logic [31:0]          i_req_wdata,
    input  logic [2:0]           i_req_funct,
    output logic                 o_rsp_valid,
    output logic [31:0]          o_rsp_rdata,
    output logic                 o_rsp_err,
    output logic [DMEM_ADDR-1:0] po_lsu_addr,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [31:0]          pwdata_o,
    output logic [2:0]           pfunct_code_o,
    input  logic [31:0]          prdata_i
);

    // Request side: valid/ready; a request is taken on a rising edge where
    // i_req_valid and o_req_ready are both high. The response is a one-cycle
    // o_rsp_valid pulse with no backpressure.

    lsu_state_e           state_q, state_d;
    logic                 we_q, we_d;
    logic [DMEM_ADDR-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [2:0]           funct_q, funct_d;
    logic [2:0]           size_q, size_d;
    logic                 err_q, err_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [1:0]           k_q, k_d;
    logic                 pen_q, pen_d;
    logic                 pwr_q, pwr_d;
    logic [DMEM_ADDR-1:0] paddr_q, paddr_d;
    logic [31:0]          pwdata_q, pwdata_d;
    logic [2:0]           pfunct_q, pfunct_d;

    logic                 chk_err;
    logic                 chk_split;
    logic [2:0]           chk_size;
    logic [1:0]           k_next;
    logic [31:0]          asm_w;

    lsu_req_check #(.DMEM_DEPTH(DMEM_DEPTH)) u_check (
        .i_we    (i_req_we),
        .i_addr  (i_req_addr),
        .i_funct (i_req_funct),
        .o_err   (chk_err),
        .o_split (chk_split),
        .o_size  (chk_size)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        funct_d  = funct_q;
        size_d   = size_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        k_d      = k_q;
        pen_d    = 1'b0;
        pwr_d    = 1'b0;
        paddr_d  = '0;
        pwdata_d = '0;
        pfunct_d = '0;
        k_next   = k_q + 2'd1;
        asm_w    = rdata_q;
        asm_w[k_q*8 +: 8] = prdata_i[7:0];

        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    addr_d  = i_req_addr[DMEM_ADDR-1:0];
                    wdata_d = i_req_wdata;
                    funct_d = i_req_funct;
                    size_d  = chk_size;
                    err_d   = chk_err;
                    rdata_d = '0;
                    k_d     = 2'd0;
                    if (chk_err) begin
                        state_d = RESP;
                    end else if (chk_split) begin
                        state_d  = SPLIT;
                        pen_d    = 1'b1;
                        pwr_d    = i_req_we;
                        paddr_d  = i_req_addr[DMEM_ADDR-1:0];
                        pwdata_d = {24'd0, i_req_wdata[7:0]};
                        pfunct_d = i_req_we ? F_SB : F_LBU;
                    end else begin
                        state_d  = ACCESS;
                        pen_d    = 1'b1;
                        pwr_d    = i_req_we;
                        paddr_d  = i_req_addr[DMEM_ADDR-1:0];
                        pwdata_d = i_req_wdata;
                        pfunct_d = i_req_funct;
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!we_q) rdata_d = prdata_i;
            end
            SPLIT: begin
                if ({1'b0, k_q} == size_q - 3'd1) begin
                    state_d = RESP;
                    if (!we_q) rdata_d = load_extend(funct_q, asm_w);
                end else begin
                    if (!we_q) rdata_d = asm_w;
                    k_d      = k_next;
                    pen_d    = 1'b1;
                    pwr_d    = we_q;
                    paddr_d  = addr_q + {{(DMEM_ADDR-2){1'b0}}, k_next};
                    pwdata_d = {24'd0, wdata_q[k_next*8 +: 8]};
                    pfunct_d = we_q ? F_SB : F_LBU;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            funct_q  <= '0;
            size_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            k_q      <= '0;
            pen_q    <= 1'b0;
            pwr_q    <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pfunct_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            funct_q  <= funct_d;
            size_q   <= size_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            k_q      <= k_d;
            pen_q    <= pen_d;
            pwr_q    <= pwr_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pfunct_q <= pfunct_d;
        end
    end

    assign o_req_ready   = (state_q == IDLE);
    assign o_rsp_valid   = (state_q == RESP);
    assign o_rsp_err     = (state_q == RESP) && err_q;
    assign o_rsp_rdata   = (state_q == RESP) ? rdata_q : 32'd0;
    assign penable_o     = pen_q;
    assign pwrite_o      = pwr_q;
    assign po_lsu_addr   = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pfunct_code_o = pfunct_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: byte memory on the port, a
// request-level reference model, directed plan then random requests.
module tb_lsu_mem_initiator;

    localparam int DEPTH = 8192;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic [2:0]  i_req_funct = '0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [12:0] po_lsu_addr;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] pwdata_o;
    logic [2:0]  pfunct_code_o;
    logic [31:0] prdata_i;

    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] ref_mem [0:DEPTH-1];

    int n_vec = 0;
    int n_bad = 0;

    lsu_mem_initiator dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_we      (i_req_we),
        .i_req_addr    (i_req_addr),
        .i_req_wdata   (i_req_wdata),
        .i_req_funct   (i_req_funct),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_rdata   (o_rsp_rdata),
        .o_rsp_err     (o_rsp_err),
        .po_lsu_addr   (po_lsu_addr),
        .penable_o     (penable_o),
        .pwrite_o      (pwrite_o),
        .pwdata_o      (pwdata_o),
        .pfunct_code_o (pfunct_code_o),
        .prdata_i      (prdata_i)
    );

    always #5 i_clk = ~i_clk;

    // Memory has no reset: writes land on any edge where the port asks.
    always @(posedge i_clk) begin
        if (penable_o && pwrite_o) begin
            mem[po_lsu_addr] <= pwdata_o[7:0];
            if (pfunct_code_o == 3'b001 || pfunct_code_o == 3'b010)
                mem[po_lsu_addr + 13'd1] <= pwdata_o[15:8];
            if (pfunct_code_o == 3'b010) begin
                mem[po_lsu_addr + 13'd2] <= pwdata_o[23:16];
                mem[po_lsu_addr + 13'd3] <= pwdata_o[31:24];
            end
        end
    end

    // Combinational read port; it returns junk when not selected.
    always_comb begin
        logic [7:0] b0, b1, b2, b3;
        b0 = mem[po_lsu_addr];
        b1 = mem[po_lsu_addr + 13'd1];
        b2 = mem[po_lsu_addr + 13'd2];
        b3 = mem[po_lsu_addr + 13'd3];
        prdata_i = 32'hA5A5_A5A5;
        if (penable_o && !pwrite_o) begin
            case (pfunct_code_o)
                3'b000:  prdata_i = {{24{b0[7]}}, b0};
                3'b001:  prdata_i = {{16{b1[7]}}, b1, b0};
                3'b010:  prdata_i = {b3, b2, b1, b0};
                3'b100:  prdata_i = {24'd0, b0};
                3'b101:  prdata_i = {16'd0, b1, b0};
                default: prdata_i = 32'h0;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] funct);
        return (funct[1:0] == 2'b00) ? 1 : (funct[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Value a correct load must return, built from the reference bytes.
    function automatic logic [31:0] ref_load(input logic [2:0] funct, input logic [31:0] addr);
        longint val;
        int     size;
        size = size_of(funct);
        val  = 0;
        for (int i = 0; i < size; i++)
            val = val + (longint'(ref_mem[13'(addr + 32'(i))]) << (8 * i));
        if (!funct[2] && size < 4 && val >= (longint'(1) << (8 * size - 1)))
            val = val - (longint'(1) << (8 * size));
        return val[31:0];
    endfunction

    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] funct);
        int          size, exp_lat, exp_beats, lat, beats;
        bit          legal, in_range, aligned, split_en, err;
        logic [31:0] exp_rd, got_rd;
        logic        got_err;
        size     = size_of(funct);
        legal    = we ? (funct <= 3'd2) : (funct <= 3'd2 || funct == 3'd4 || funct == 3'd5);
        in_range = (longint'(addr) + size - 1) <= longint'(DEPTH - 1);
        aligned  = (addr % 32'(size)) == 0;
`ifdef LSU_MISALIGN_SPLIT_EN
        split_en = 1'b1;
`else
        split_en = 1'b0;
`endif
        err       = !legal || !in_range || (!aligned && !split_en);
        exp_lat   = err ? 1 : (aligned ? 2 : 1 + size);
        exp_beats = err ? 0 : (aligned ? 1 : size);
        exp_rd    = (err || we) ? 32'd0 : ref_load(funct, addr);
        if (!err && we)
            for (int i = 0; i < size; i++) ref_mem[13'(addr + 32'(i))] = wdata[8*i +: 8];

        @(negedge i_clk);
        chk("ready_idle", {31'd0, o_req_ready}, 32'd1);
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        i_req_funct = funct;
        @(posedge i_clk);
        lat = 0; beats = 0; got_rd = '0; got_err = 1'b0;
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(negedge i_clk);
            if (penable_o) begin
                chk("bus_write", {31'd0, pwrite_o}, {31'd0, we});
                if (aligned) begin
                    chk("bus_addr", {19'd0, po_lsu_addr}, {19'd0, addr[12:0]});
                    chk("bus_funct", {29'd0, pfunct_code_o}, {29'd0, funct});
                    chk("bus_wdata", pwdata_o, wdata);
                end else begin
                    chk("split_addr", {19'd0, po_lsu_addr}, {19'd0, 13'(addr + 32'(beats))});
                    chk("split_funct", {29'd0, pfunct_code_o}, we ? 32'd0 : 32'd4);
                    chk("split_wdata", pwdata_o, {24'd0, wdata[8*(beats%4) +: 8]});
                end
                beats++;
            end
            if (o_rsp_valid) begin
                lat     = c;
                got_rd  = o_rsp_rdata;
                got_err = o_rsp_err;
            end else begin
                // Anything presented while busy must be ignored.
                i_req_valid = 1'($urandom_range(0, 1));
                i_req_we    = 1'($urandom_range(0, 1));
                i_req_addr  = $urandom;
                i_req_funct = 3'($urandom_range(0, 7));
            end
        end
        i_req_valid = 1'b0;
        chk("rsp_latency", 32'(lat), 32'(exp_lat));
        chk("rsp_err", {31'd0, got_err}, {31'd0, err});
        chk("rsp_rdata", got_rd, exp_rd);
        chk("bus_beats", 32'(beats), 32'(exp_beats));
    endtask

    initial begin
        logic [31:0] rst_wdata;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end

        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
        chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
        chk("rst_penable", {31'd0, penable_o}, 32'd0);
        chk("rst_pwrite", {31'd0, pwrite_o}, 32'd0);
        chk("rst_paddr", {19'd0, po_lsu_addr}, 32'd0);
        chk("rst_pwdata", pwdata_o, 32'd0);
        chk("rst_pfunct", {29'd0, pfunct_code_o}, 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_ready", {31'd0, o_req_ready}, 32'd1);

        // Directed plan
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010);   // SW
        do_req(1'b0, 32'h10, 32'h0, 3'b010);           // LW
        do_req(1'b0, 32'h10, 32'h0, 3'b000);           // LB
        do_req(1'b0, 32'h10, 32'h0, 3'b100);           // LBU
        do_req(1'b0, 32'h12, 32'h0, 3'b001);           // LH
        do_req(1'b0, 32'h12, 32'h0, 3'b101);           // LHU
        do_req(1'b0, 32'h11, 32'h0, 3'b010);           // misaligned LW
        do_req(1'b1, 32'h21, 32'h1234_5678, 3'b001);   // misaligned SH
        do_req(1'b0, 32'h21, 32'h0, 3'b001);
        do_req(1'b0, 32'h0000_1FFC, 32'h0, 3'b010);    // top word
        do_req(1'b0, 32'h0000_2000, 32'h0, 3'b001);    // past end
        do_req(1'b1, 32'hFFFF_FFFF, 32'h55, 3'b000);   // no-wrap range check
        do_req(1'b0, 32'h20, 32'h0, 3'b011);           // illegal load funct
        do_req(1'b1, 32'h20, 32'h77, 3'b100);          // illegal store funct

        // Reset during the ACCESS cycle of a store
        rst_wdata = $urandom;
        @(negedge i_clk);
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_addr  = 32'h40;
        i_req_wdata = rst_wdata;
        i_req_funct = 3'b010;
        @(posedge i_clk);
        @(negedge i_clk);
        i_req_valid = 1'b0;
        chk("rst_mid_penable", {31'd0, penable_o}, 32'd1);
        i_rst = 1'b1;
        for (int i = 0; i < 4; i++) ref_mem[8'h40 + i] = rst_wdata[8*i +: 8];
        @(negedge i_clk);
        chk("rst_mid_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst_mid_penable_off", {31'd0, penable_o}, 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_mid_no_rsp2", {31'd0, o_rsp_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, o_req_ready}, 32'd1);
        do_req(1'b0, 32'h40, 32'h0, 3'b010);

        // Random requests
        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 63));
                1:       a = 32'(DEPTH - 8 + $urandom_range(0, 15));
                2:       a = $urandom;
                default: a = 32'($urandom_range(0, DEPTH - 1));
            endcase
            do_req(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
